// File: rtl/bfp_pkg.sv
// Shared constants and helpers for the bfp range selector family.
package bfp_pkg;

    localparam logic MODE_FIXED    = 1'b0;
    localparam logic MODE_RR       = 1'b1;
    localparam int   DEFAULT_WIDTH = 8;

    // Index width that never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bfp_rr_next.sv
// Round-robin successor search: first valid channel after cur_ch, wrapping modulo N_CH.
// Purely combinational; falls back to cur_ch+1 when no channel is valid.
module bfp_rr_next
    import bfp_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [SEL_W-1:0] cur_ch,
    input  logic [N_CH-1:0]  in_valid,
    output logic [SEL_W-1:0] next_ch
);

    logic [N_CH-1:0] rot;
    int              offset;

    always_comb begin
        rot = '0;
        // rot[0] is the channel just after cur_ch; the last bit is cur_ch itself.
        for (int j = 0; j < N_CH; j++) begin
            rot[j] = in_valid[(int'(cur_ch) + 1 + j) % N_CH];
        end
        offset = 0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                offset = j;
            end
        end
        next_ch = SEL_W'((int'(cur_ch) + 1 + offset) % N_CH);
    end

endmodule

// File: rtl/bfp_range_selector.sv
// N-channel range-stream selector (fixed select or round-robin) into one registered output.
// Latency 1 clk, full throughput; a stalled output drops all in_ready and holds out_* stable.
module bfp_range_selector
    import bfp_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = clog2_min1(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   sel_load,
    output logic                   sel_err,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SEL_W-1:0] cur_ch;
    logic [SEL_W-1:0] cur_ch_nxt;
    logic [SEL_W-1:0] rr_ch;
    logic             free;
    logic             xfer;
    logic             sel_err_nxt;
    logic [WIDTH-1:0] mux_data;

    assign free = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = free && (cur_ch == SEL_W'(i)) && !rst;
        end
    end

    assign xfer     = |(in_valid & in_ready);
    assign mux_data = in_data[int'(cur_ch)*WIDTH +: WIDTH];

    bfp_rr_next #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_next (
        .cur_ch   (cur_ch),
        .in_valid (in_valid),
        .next_ch  (rr_ch)
    );

    // A stalled valid channel keeps its slot; an idle one is skipped.
    always_comb begin
        cur_ch_nxt  = cur_ch;
        sel_err_nxt = 1'b0;
        if (mode == MODE_FIXED) begin
            if (sel_load) begin
                if (int'(sel) < N_CH) begin
                    cur_ch_nxt = sel;
                end else begin
                    sel_err_nxt = 1'b1;
                end
            end
        end else if (xfer || !in_valid[cur_ch]) begin
            cur_ch_nxt = rr_ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch    <= '0;
            sel_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            cur_ch  <= cur_ch_nxt;
            sel_err <= sel_err_nxt;
            if (xfer) begin
                out_data  <= mux_data;
                out_ch    <= cur_ch;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bfp_range_selector.sv
// Bench for bfp_range_selector: a 4-channel and a 3-channel instance share clock and reset.
module tb_bfp_range_selector;
    import bfp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4, sel_load4, sel_err4, out_valid4, out_ready4;
    logic [1:0]  sel4, out_ch4;
    logic [7:0]  out_data4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, sel_load3, sel_err3, out_valid3, out_ready3;
    logic [1:0]  sel3, out_ch3;
    logic [7:0]  out_data3;

    bfp_range_selector #(.N_CH(4), .WIDTH(8)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .sel(sel4), .sel_load(sel_load4), .sel_err(sel_err4),
        .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    bfp_range_selector #(.N_CH(3), .WIDTH(8)) u3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .sel_load(sel_load3), .sel_err(sel_err3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ready;
    } sel_vec_t;

    exp_t       exp4[$];
    exp_t       exp3[$];
    logic [7:0] src4[4][$];
    logic [7:0] src3[3][$];
    sel_vec_t   tbl[5];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input int ch, input logic [7:0] d);
        exp_t e;
        src4[ch].push_back(d);
        e.data = d;
        e.ch   = 2'(ch);
        exp4.push_back(e);
    endtask

    task automatic push3(input int ch, input logic [7:0] d);
        exp_t e;
        src3[ch].push_back(d);
        e.data = d;
        e.ch   = 2'(ch);
        exp3.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_valid4[i]        = (src4[i].size() > 0);
            in_data4[i*8 +: 8]  = (src4[i].size() > 0) ? src4[i][0] : 8'h00;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid3[i]        = (src3[i].size() > 0);
            in_data3[i*8 +: 8]  = (src3[i].size() > 0) ? src3[i][0] : 8'h00;
        end
    endtask

    // One clock: check outputs at the falling edge, retire accepted source words after the rise.
    task automatic cycle();
        logic [3:0] acc4;
        logic [2:0] acc3;
        exp_t       e;
        logic [7:0] tmp;
        @(negedge clk);
        acc4 = in_valid4 & in_ready4;
        acc3 = in_valid3 & in_ready3;
        check("u4_ready_onehot", 32'($onehot0(in_ready4)), 32'd1);
        check("u3_ready_onehot", 32'($onehot0(in_ready3)), 32'd1);
        if (out_valid4 && out_ready4) begin
            if (exp4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u4_unexpected: got data %0h ch %0d, expected no word", out_data4, out_ch4);
            end else begin
                e = exp4.pop_front();
                check("u4_data", 32'(out_data4), 32'(e.data));
                check("u4_ch", 32'(out_ch4), 32'(e.ch));
            end
        end
        if (out_valid3 && out_ready3) begin
            if (exp3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u3_unexpected: got data %0h ch %0d, expected no word", out_data3, out_ch3);
            end else begin
                e = exp3.pop_front();
                check("u3_data", 32'(out_data3), 32'(e.data));
                check("u3_ch", 32'(out_ch3), 32'(e.ch));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc4[i] && src4[i].size() > 0) tmp = src4[i].pop_front();
        for (int i = 0; i < 3; i++) if (acc3[i] && src3[i].size() > 0) tmp = src3[i].pop_front();
        drive();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp4.size() > 0 || exp3.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        check("drain_u4", 32'(exp4.size()), 32'd0);
        check("drain_u3", 32'(exp3.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{sel: 2'd0, data: 8'h3C, ready: 4'b0001};
        tbl[1] = '{sel: 2'd3, data: 8'hC3, ready: 4'b1000};
        tbl[2] = '{sel: 2'd1, data: 8'h5A, ready: 4'b0010};
        tbl[3] = '{sel: 2'd2, data: 8'hA5, ready: 4'b0100};
        tbl[4] = '{sel: 2'd3, data: 8'hFF, ready: 4'b1000};

        rst = 1'b1;
        in_data4 = '0; in_valid4 = '0; mode4 = MODE_FIXED; sel4 = '0; sel_load4 = 1'b0; out_ready4 = 1'b1;
        in_data3 = '0; in_valid3 = '0; mode3 = MODE_FIXED; sel3 = '0; sel_load3 = 1'b0; out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_out_data", 32'(out_data4), 32'd0);
        check("rst_out_ch", 32'(out_ch4), 32'd0);
        check("rst_sel_err", 32'(sel_err4), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd0);
        check("rst_in_ready3", 32'(in_ready3), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready4", 32'(in_ready4), 32'h1);

        // Fixed select on ch2, three back-to-back words.
        sel4 = 2'd2; sel_load4 = 1'b1;
        cycle();
        sel_load4 = 1'b0;
        check("t1_ready", 32'(in_ready4), 32'b0100);
        push4(2, 8'h11); push4(2, 8'h22); push4(2, 8'h33);
        drive();
        repeat (4) cycle();
        check("t1_throughput", 32'(exp4.size()), 32'd0);
        check("t1_idle_valid", 32'(out_valid4), 32'd0);

        // Backpressure while 0x22 is held.
        push4(2, 8'h11); push4(2, 8'h22); push4(2, 8'h33);
        drive();
        cycle();
        cycle();
        check("t2_hold_pre", 32'(out_data4), 32'h22);
        out_ready4 = 1'b0;
        #1;
        check("t2_ready_stall", 32'(in_ready4), 32'd0);
        repeat (3) begin
            cycle();
            check("t2_stall_data", 32'(out_data4), 32'h22);
            check("t2_stall_ch", 32'(out_ch4), 32'd2);
            check("t2_stall_valid", 32'(out_valid4), 32'd1);
            check("t2_stall_ready", 32'(in_ready4), 32'd0);
        end
        out_ready4 = 1'b1;
        cycle();
        check("t2_release_data", 32'(out_data4), 32'h33);
        cycle();
        check("t2_none_lost", 32'(exp4.size()), 32'd0);

        // Select sweep table.
        for (int k = 0; k < 5; k++) begin
            sel4 = tbl[k].sel; sel_load4 = 1'b1;
            cycle();
            sel_load4 = 1'b0;
            check("tbl_ready", 32'(in_ready4), 32'(tbl[k].ready));
            check("tbl_sel_err", 32'(sel_err4), 32'd0);
            push4(int'(tbl[k].sel), tbl[k].data);
            drive();
            drain(5);
        end

        // Out-of-range select on the 3-channel instance.
        sel3 = 2'd3; sel_load3 = 1'b1;
        cycle();
        sel_load3 = 1'b0;
        check("t3_sel_err_hi", 32'(sel_err3), 32'd1);
        check("t3_cur_kept", 32'(in_ready3), 32'b001);
        cycle();
        check("t3_sel_err_lo", 32'(sel_err3), 32'd0);
        check("t3_cur_kept2", 32'(in_ready3), 32'b001);
        push3(0, 8'h50); push3(1, 8'h61);
        sel3 = 2'd1; sel_load3 = 1'b1;
        drive();
        cycle();
        sel_load3 = 1'b0;
        check("t3_good_no_err", 32'(sel_err3), 32'd0);
        check("t3_new_ready", 32'(in_ready3), 32'b010);
        drain(5);

        // Idle round-robin wraps 2 -> 0 on a 3-channel instance.
        sel3 = 2'd2; sel_load3 = 1'b1;
        cycle();
        sel_load3 = 1'b0;
        check("t5_at_ch2", 32'(in_ready3), 32'b100);
        mode3 = MODE_RR;
        cycle();
        check("t5_wrap", 32'(in_ready3), 32'b001);
        cycle();
        check("t5_step", 32'(in_ready3), 32'b010);

        // Only ch0 valid: it takes every slot.
        for (int k = 0; k < 6; k++) push3(0, 8'hE0 + 8'(k));
        drive();
        repeat (8) cycle();
        check("t5_ch0_every_slot", 32'(exp3.size()), 32'd0);
        mode3 = MODE_FIXED;

        // Round-robin with all four channels valid.
        sel4 = 2'd0; sel_load4 = 1'b1;
        cycle();
        sel_load4 = 1'b0;
        mode4 = MODE_RR;
        for (int i = 0; i < 4; i++) src4[i].push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) src4[i].push_back(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) exp4.push_back('{data: 8'hA0 + 8'(i), ch: 2'(i)});
        for (int i = 0; i < 4; i++) exp4.push_back('{data: 8'hB0 + 8'(i), ch: 2'(i)});
        drive();
        repeat (9) cycle();
        check("t4_all_valid", 32'(exp4.size()), 32'd0);

        // Round-robin with only ch1 and ch3 valid.
        mode4 = MODE_FIXED;
        sel4 = 2'd0; sel_load4 = 1'b1;
        cycle();
        sel_load4 = 1'b0;
        mode4 = MODE_RR;
        src4[1].push_back(8'hC1); src4[1].push_back(8'hD1);
        src4[3].push_back(8'hC3); src4[3].push_back(8'hD3);
        exp4.push_back('{data: 8'hC1, ch: 2'd1});
        exp4.push_back('{data: 8'hC3, ch: 2'd3});
        exp4.push_back('{data: 8'hD1, ch: 2'd1});
        exp4.push_back('{data: 8'hD3, ch: 2'd3});
        drive();
        repeat (6) cycle();
        check("t4_sparse", 32'(exp4.size()), 32'd0);
        mode4 = MODE_FIXED;

        // Asynchronous reset between edges with a word in the output register.
        sel4 = 2'd3; sel_load4 = 1'b1;
        cycle();
        sel_load4 = 1'b0;
        src4[3].push_back(8'h77); src4[3].push_back(8'h88);
        drive();
        cycle();
        check("t6_loaded", 32'(out_valid4), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid4), 32'd0);
        check("t6_async_ready", 32'(in_ready4), 32'd0);
        check("t6_async_data", 32'(out_data4), 32'd0);
        src4[3].delete();
        drive();
        cycle();
        rst = 1'b0;
        #1;
        check("t6_restart_ready", 32'(in_ready4), 32'h1);
        check("t6_restart_valid", 32'(out_valid4), 32'd0);
        push4(0, 8'h99);
        drive();
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
